alu_pipe_unit: RTL and testbench
================================

// Module: alu_pipe_unit
// PURPOSE
// Parametrised, pipelined multi-channel integer ALU behind the issue/ROB path.
// NUM_CH independent lanes each take an op (two operands, func code, ROB tag).
// Each lane returns the result two cycles later with valid/ready backpressure
// toward the CDB/ROB. A global flush kills in-flight work on mispredict/exception.
// PARAMETERS
// OPE     32  operand/result width in bits (>=8, power of two)
// FUNC    17  func-code width
// TAGW    6   ROB tag width
// NUM_CH  2   number of independent lanes
// PORTS
// clk        in   1             clock, all logic rising-edge
// rst        in   1             synchronous reset, active-high
// flush      in   1             synchronous kill of all in-flight ops
// in_valid   in   NUM_CH        per-lane op valid
// in_ready   out  NUM_CH        per-lane accept; transfer = in_valid & in_ready
// in_opa     in   NUM_CH*OPE    operand A, lane c at [c*OPE +: OPE]
// in_opb     in   NUM_CH*OPE    operand B, same packing
// in_func    in   NUM_CH*FUNC   func code, same packing
// in_tag     in   NUM_CH*TAGW   ROB tag, same packing
// out_valid  out  NUM_CH        result valid
// out_ready  in   NUM_CH        consumer accept; transfer = out_valid & out_ready
// out_result out  NUM_CH*OPE    result
// out_tag    out  NUM_CH*TAGW   ROB tag travelling with result
// out_err    out  NUM_CH        1 = unsupported func code (result forced 0)
// BEHAVIOUR
// - Reset: all valids 0, out_result/out_tag/out_err 0, in_ready 0 during rst.
// - Per lane two register stages: S1 (captured op), S2 (result). Result computed
//   combinationally from S1, registered into S2. Accept in cycle N -> out_valid N+2.
// - Advance: s2_free = !s2_v | out_ready; S1->S2 when s1_v & s2_free;
//   in_ready = !rst & !flush & (!s1_v | s2_free). Sustained 1 op/cycle/lane.
// - Backpressure: out_valid & !out_ready holds out_result/out_tag/out_err stable;
//   S1 fills, then in_ready drops. No op is ever dropped or duplicated.
// - Lanes are fully independent; no cross-lane ordering or stall coupling.
// - Func codes: 01 ADD, 02 SUB, 03 AND, 04 OR, 05 XOR, 06 SLL, 07 SRL, 08 SRA,
//   09 SLT (signed, result 0/1), 0A SLTU (unsigned, 0/1). Other -> 0, out_err=1.
// - Arithmetic wraps modulo 2^OPE; no carry/overflow output. Shift amount =
//   opb[log2(OPE)-1:0], upper opb bits ignored. SRA sign-fills from opa[OPE-1].
// - Flush: in the cycle flush=1, inputs are not accepted. Next cycle, all S1/S2
//   valids are 0. An out_valid shown in the flush cycle is not a transfer even
//   if out_ready=1. Flush and rst act identically on valids. Flush does not clear
//   data regs.
// - Reset or flush mid-stream: in-flight ops discarded; first op accepted after
//   deassertion appears 2 cycles later with its own tag.
// TESTING
// - Lane0 ADD 0xFFFFFFFF+0x1 tag 5 -> cycle+2 out_result 0, tag 5, err 0.
// - Lane1 SRA 0x80000000 by opb=0x24 (amt 4) -> 0xF8000000; SLT -1,1 -> 1;
//   SLTU -1,1 -> 0.
// - Back-to-back 8 ops/lane, out_ready=1 -> 8 results in order, one per cycle,
//   from cycle+2.
// - out_ready=0 for 5 cycles after 3 ops: in_ready drops after 2 accepted, lane
//   holds result 1 stable; release -> results 1,2,3 in order, none lost.
// - Flush with both stages full on both lanes -> next cycle out_valid=00;
//   no stale tag emerges later.
// - func 0x1F -> out_result 0, out_err 1; rst mid-stream -> all valids 0 next cycle.

Source files
------------

// File: rtl/alu_pipe_unit.sv
// Multi-lane pipelined integer ALU: per lane, an op capture stage (S1) and a result stage (S2),
// with valid/ready handshakes on both sides and a global flush that kills in-flight work.
module alu_pipe_unit #(
    parameter int OPE    = 32,
    parameter int FUNC   = 17,
    parameter int TAGW   = 6,
    parameter int NUM_CH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*OPE-1:0]    in_opa,
    input  logic [NUM_CH*OPE-1:0]    in_opb,
    input  logic [NUM_CH*FUNC-1:0]   in_func,
    input  logic [NUM_CH*TAGW-1:0]   in_tag,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*OPE-1:0]    out_result,
    output logic [NUM_CH*TAGW-1:0]   out_tag,
    output logic [NUM_CH-1:0]        out_err
);

    localparam int SHW = $clog2(OPE);

    localparam logic [FUNC-1:0] F_ADD  = FUNC'(1);
    localparam logic [FUNC-1:0] F_SUB  = FUNC'(2);
    localparam logic [FUNC-1:0] F_AND  = FUNC'(3);
    localparam logic [FUNC-1:0] F_OR   = FUNC'(4);
    localparam logic [FUNC-1:0] F_XOR  = FUNC'(5);
    localparam logic [FUNC-1:0] F_SLL  = FUNC'(6);
    localparam logic [FUNC-1:0] F_SRL  = FUNC'(7);
    localparam logic [FUNC-1:0] F_SRA  = FUNC'(8);
    localparam logic [FUNC-1:0] F_SLT  = FUNC'(9);
    localparam logic [FUNC-1:0] F_SLTU = FUNC'(10);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        logic              s1_v;
        logic [OPE-1:0]    s1_opa;
        logic [OPE-1:0]    s1_opb;
        logic [FUNC-1:0]   s1_func;
        logic [TAGW-1:0]   s1_tag;
        logic              s2_v;
        logic [OPE-1:0]    s2_res;
        logic [TAGW-1:0]   s2_tag;
        logic              s2_err;
        logic [OPE-1:0]    alu_res;
        logic              alu_err;
        logic [SHW-1:0]    shamt;
        logic              s2_free;
        logic              s1_adv;
        logic              accept;

        assign s2_free     = !s2_v || out_ready[c];
        assign s1_adv      = s1_v && s2_free;
        assign in_ready[c] = !rst && !flush && (!s1_v || s2_free);
        assign accept      = in_valid[c] && in_ready[c];
        assign shamt       = s1_opb[SHW-1:0];

        // NOTE: every variable gets a default before the case so no latch is inferred.
        always_comb begin
            alu_res = '0;
            alu_err = 1'b0;
            case (s1_func)
                F_ADD:   alu_res = s1_opa + s1_opb;
                F_SUB:   alu_res = s1_opa - s1_opb;
                F_AND:   alu_res = s1_opa & s1_opb;
                F_OR:    alu_res = s1_opa | s1_opb;
                F_XOR:   alu_res = s1_opa ^ s1_opb;
                F_SLL:   alu_res = s1_opa << shamt;
                F_SRL:   alu_res = s1_opa >> shamt;
                F_SRA:   alu_res = $signed(s1_opa) >>> shamt;
                F_SLT:   alu_res = OPE'($signed(s1_opa) < $signed(s1_opb));
                F_SLTU:  alu_res = OPE'(s1_opa < s1_opb);
                default: alu_err = 1'b1;
            endcase
        end

        // NOTE: S1 operand registers carry no reset; s1_v alone qualifies them.
        always_ff @(posedge clk) begin
            if (accept) begin
                s1_opa  <= in_opa[c*OPE +: OPE];
                s1_opb  <= in_opb[c*OPE +: OPE];
                s1_func <= in_func[c*FUNC +: FUNC];
                s1_tag  <= in_tag[c*TAGW +: TAGW];
            end
        end

        // NOTE: sequential state uses non-blocking assignments only.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_v   <= 1'b0;
                s2_v   <= 1'b0;
                s2_res <= '0;
                s2_tag <= '0;
                s2_err <= 1'b0;
            end else if (flush) begin
                // Flush kills valids only; an out_valid shown now is not consumed.
                s1_v <= 1'b0;
                s2_v <= 1'b0;
            end else begin
                if (s1_adv) begin
                    s2_v   <= 1'b1;
                    s2_res <= alu_res;
                    s2_tag <= s1_tag;
                    s2_err <= alu_err;
                end else if (out_ready[c]) begin
                    s2_v <= 1'b0;
                end
                if (accept) begin
                    s1_v <= 1'b1;
                end else if (s1_adv) begin
                    s1_v <= 1'b0;
                end
            end
        end

        assign out_valid[c]                = s2_v;
        assign out_result[c*OPE +: OPE]    = s2_res;
        assign out_tag[c*TAGW +: TAGW]     = s2_tag;
        assign out_err[c]                  = s2_err;
    end

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Directed testbench for alu_pipe_unit: functions, latency, throughput, backpressure,
// flush and reset behaviour on both lanes.
module tb_alu_pipe_unit;

    localparam int OPE    = 32;
    localparam int FUNC   = 17;
    localparam int TAGW   = 6;
    localparam int NUM_CH = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [NUM_CH*OPE-1:0]   in_opa;
    logic [NUM_CH*OPE-1:0]   in_opb;
    logic [NUM_CH*FUNC-1:0]  in_func;
    logic [NUM_CH*TAGW-1:0]  in_tag;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH-1:0]       out_ready;
    logic [NUM_CH*OPE-1:0]   out_result;
    logic [NUM_CH*TAGW-1:0]  out_tag;
    logic [NUM_CH-1:0]       out_err;

    int checks = 0;
    int errors = 0;

    // Vector table shared by the function tests
    logic [31:0] va   [16];
    logic [31:0] vb   [16];
    logic [16:0] vf   [16];
    logic [31:0] vexp [16];
    logic        verr [16];

    alu_pipe_unit #(.OPE(OPE), .FUNC(FUNC), .TAGW(TAGW), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opa(in_opa), .in_opb(in_opb), .in_func(in_func), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int lane, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [16:0] f, input logic [5:0] t);
        in_valid[lane]            = v;
        in_opa[lane*OPE +: OPE]   = a;
        in_opb[lane*OPE +: OPE]   = b;
        in_func[lane*FUNC +: FUNC] = f;
        in_tag[lane*TAGW +: TAGW] = t;
    endtask

    function automatic logic [31:0] res_of(input int lane);
        return out_result[lane*OPE +: OPE];
    endfunction

    function automatic logic [5:0] tag_of(input int lane);
        return out_tag[lane*TAGW +: TAGW];
    endfunction

    // Streams n table entries into one lane back-to-back and checks each result two cycles later
    task automatic run_table(input int lane, input int n, input logic [5:0] tagbase);
        for (int t = 0; t <= n; t++) begin
            if (t < n) begin
                checks++;
                if (in_ready[lane] !== 1'b1) begin
                    errors++;
                    $display("FAIL table_in_ready lane%0d op%0d: got %b want 1", lane, t, in_ready[lane]);
                end
                drive(lane, 1'b1, va[t], vb[t], vf[t], tagbase + 6'(t));
            end else begin
                drive(lane, 1'b0, '0, '0, '0, '0);
            end
            tick();
            if (t >= 1) begin
                checks++;
                if (out_valid[lane] !== 1'b1 || res_of(lane) !== vexp[t-1] ||
                    tag_of(lane) !== tagbase + 6'(t-1) || out_err[lane] !== verr[t-1]) begin
                    errors++;
                    $display("FAIL table lane%0d op%0d: got v=%b res=%h tag=%0d err=%b want v=1 res=%h tag=%0d err=%b",
                             lane, t-1, out_valid[lane], res_of(lane), tag_of(lane), out_err[lane],
                             vexp[t-1], tagbase + 6'(t-1), verr[t-1]);
                end
            end
        end
        tick();
        checks++;
        if (out_valid[lane] !== 1'b0) begin
            errors++;
            $display("FAIL table_drain lane%0d: got out_valid=%b want 0", lane, out_valid[lane]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        in_valid = '0;
        in_opa = '0;
        in_opb = '0;
        in_func = '0;
        in_tag = '0;
        out_ready = '1;
        tick();
        tick();
        checks++;
        if (out_valid !== 2'b00 || out_result !== '0 || out_tag !== '0 || out_err !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b res=%h tag=%h err=%b want all 0",
                     out_valid, out_result, out_tag, out_err);
        end
        checks++;
        if (in_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 00", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 2'b11) begin
            errors++;
            $display("FAIL post_reset_in_ready: got %b want 11", in_ready);
        end
    endtask

    task automatic test_add_latency();
        drive(0, 1'b1, 32'hFFFF_FFFF, 32'h1, 17'h1, 6'd5);
        tick();
        drive(0, 1'b0, '0, '0, '0, '0);
        checks++;
        if (out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL add_early lane0: got out_valid=%b want 0 one cycle after accept", out_valid[0]);
        end
        tick();
        checks++;
        if (out_valid[0] !== 1'b1 || res_of(0) !== 32'h0 || tag_of(0) !== 6'd5 || out_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap lane0: got v=%b res=%h tag=%0d err=%b want v=1 res=0 tag=5 err=0",
                     out_valid[0], res_of(0), tag_of(0), out_err[0]);
        end
        tick();
        checks++;
        if (out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL add_drain lane0: got out_valid=%b want 0", out_valid[0]);
        end
    endtask

    task automatic test_funcs_lane0();
        va[0] = 32'd5;          vb[0] = 32'd7;          vf[0] = 17'h2;  vexp[0] = 32'hFFFF_FFFE; verr[0] = 1'b0;
        va[1] = 32'hF0F0_1234;  vb[1] = 32'h0FF0_FF00;  vf[1] = 17'h3;  vexp[1] = 32'h00F0_1200; verr[1] = 1'b0;
        va[2] = 32'hF000_0000;  vb[2] = 32'h0000_000F;  vf[2] = 17'h4;  vexp[2] = 32'hF000_000F; verr[2] = 1'b0;
        va[3] = 32'hAAAA_5555;  vb[3] = 32'hFFFF_0000;  vf[3] = 17'h5;  vexp[3] = 32'h5555_5555; verr[3] = 1'b0;
        va[4] = 32'h1;          vb[4] = 32'h3F;         vf[4] = 17'h6;  vexp[4] = 32'h8000_0000; verr[4] = 1'b0;
        va[5] = 32'h8000_0000;  vb[5] = 32'h21;         vf[5] = 17'h7;  vexp[5] = 32'h4000_0000; verr[5] = 1'b0;
        va[6] = 32'd5;          vb[6] = 32'hFFFF_FFFF;  vf[6] = 17'h9;  vexp[6] = 32'h0;         verr[6] = 1'b0;
        va[7] = 32'd5;          vb[7] = 32'hFFFF_FFFF;  vf[7] = 17'hA;  vexp[7] = 32'h1;         verr[7] = 1'b0;
        va[8] = 32'd3;          vb[8] = 32'd4;          vf[8] = 17'h1F; vexp[8] = 32'h0;         verr[8] = 1'b1;
        va[9] = 32'd3;          vb[9] = 32'd4;          vf[9] = 17'h0;  vexp[9] = 32'h0;         verr[9] = 1'b1;
        run_table(0, 10, 6'd10);
    endtask

    task automatic test_funcs_lane1();
        va[0] = 32'h8000_0000;  vb[0] = 32'h24;         vf[0] = 17'h8;  vexp[0] = 32'hF800_0000; verr[0] = 1'b0;
        va[1] = 32'hFFFF_FFFF;  vb[1] = 32'h1;          vf[1] = 17'h9;  vexp[1] = 32'h1;         verr[1] = 1'b0;
        va[2] = 32'hFFFF_FFFF;  vb[2] = 32'h1;          vf[2] = 17'hA;  vexp[2] = 32'h0;         verr[2] = 1'b0;
        va[3] = 32'h4000_0000;  vb[3] = 32'h1;          vf[3] = 17'h8;  vexp[3] = 32'h2000_0000; verr[3] = 1'b0;
        va[4] = 32'h7;          vb[4] = 32'h1;          vf[4] = 17'h1F; vexp[4] = 32'h0;         verr[4] = 1'b1;
        run_table(1, 5, 6'd30);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t <= 9; t++) begin
            for (int l = 0; l < NUM_CH; l++) begin
                if (t < 8) drive(l, 1'b1, 32'(t), 32'(100 * l), 17'h1, 6'(t + 8 * l));
                else       drive(l, 1'b0, '0, '0, '0, '0);
            end
            if (t < 8) begin
                checks++;
                if (in_ready !== 2'b11) begin
                    errors++;
                    $display("FAIL b2b_in_ready cycle%0d: got %b want 11", t, in_ready);
                end
            end
            tick();
            for (int l = 0; l < NUM_CH; l++) begin
                if (t >= 1 && t <= 8) begin
                    checks++;
                    if (out_valid[l] !== 1'b1 || res_of(l) !== 32'(t - 1 + 100 * l) ||
                        tag_of(l) !== 6'(t - 1 + 8 * l)) begin
                        errors++;
                        $display("FAIL b2b lane%0d op%0d: got v=%b res=%h tag=%0d want v=1 res=%h tag=%0d",
                                 l, t-1, out_valid[l], res_of(l), tag_of(l),
                                 32'(t - 1 + 100 * l), 6'(t - 1 + 8 * l));
                    end
                end else if (t == 9) begin
                    checks++;
                    if (out_valid[l] !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_drain lane%0d: got out_valid=%b want 0", l, out_valid[l]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready[0] = 1'b0;
        drive(0, 1'b1, 32'd1, 32'd0, 17'h1, 6'd41);
        tick();
        drive(0, 1'b1, 32'd2, 32'd0, 17'h1, 6'd42);
        checks++;
        if (in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_accept: got in_ready=%b want 1", in_ready[0]);
        end
        tick();
        drive(0, 1'b1, 32'd3, 32'd0, 17'h1, 6'd43);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || res_of(0) !== 32'd1 || tag_of(0) !== 6'd41) begin
                errors++;
                $display("FAIL bp_hold cycle%0d: got rdy=%b v=%b res=%h tag=%0d want rdy=0 v=1 res=1 tag=41",
                         k, in_ready[0], out_valid[0], res_of(0), tag_of(0));
            end
            checks++;
            if (in_ready[1] !== 1'b1) begin
                errors++;
                $display("FAIL bp_lane1_independent cycle%0d: got in_ready[1]=%b want 1", k, in_ready[1]);
            end
            tick();
        end
        out_ready[0] = 1'b1;
        #1;
        checks++;
        if (in_ready[0] !== 1'b1 || res_of(0) !== 32'd1) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b res=%h want rdy=1 res=1", in_ready[0], res_of(0));
        end
        tick();
        drive(0, 1'b0, '0, '0, '0, '0);
        for (int k = 2; k <= 3; k++) begin
            checks++;
            if (out_valid[0] !== 1'b1 || res_of(0) !== 32'(k) || tag_of(0) !== 6'(40 + k)) begin
                errors++;
                $display("FAIL bp_order op%0d: got v=%b res=%h tag=%0d want v=1 res=%0d tag=%0d",
                         k, out_valid[0], res_of(0), tag_of(0), k, 40 + k);
            end
            tick();
        end
        checks++;
        if (out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got out_valid=%b want 0", out_valid[0]);
        end
    endtask

    task automatic test_flush();
        out_ready = 2'b00;
        drive(0, 1'b1, 32'd1, 32'd1, 17'h1, 6'd10);
        drive(1, 1'b1, 32'd2, 32'd2, 17'h1, 6'd20);
        tick();
        drive(0, 1'b1, 32'd3, 32'd3, 17'h1, 6'd11);
        drive(1, 1'b1, 32'd4, 32'd4, 17'h1, 6'd21);
        tick();
        drive(0, 1'b1, 32'd9, 32'd9, 17'h1, 6'd30);
        drive(1, 1'b1, 32'd9, 32'd9, 17'h1, 6'd31);
        checks++;
        if (out_valid !== 2'b11 || in_ready !== 2'b00) begin
            errors++;
            $display("FAIL flush_setup: got v=%b rdy=%b want v=11 rdy=00", out_valid, in_ready);
        end
        flush = 1'b1;
        out_ready = 2'b11;
        #1;
        checks++;
        if (in_ready !== 2'b00) begin
            errors++;
            $display("FAIL flush_in_ready: got %b want 00", in_ready);
        end
        tick();
        flush = 1'b0;
        drive(0, 1'b0, '0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 2'b00) begin
                errors++;
                $display("FAIL flush_stale cycle%0d: got out_valid=%b tags=%h want 00", k, out_valid, out_tag);
            end
            tick();
        end
        drive(0, 1'b1, 32'd6, 32'd1, 17'h2, 6'd7);
        tick();
        drive(0, 1'b0, '0, '0, '0, '0);
        tick();
        checks++;
        if (out_valid !== 2'b01 || res_of(0) !== 32'd5 || tag_of(0) !== 6'd7) begin
            errors++;
            $display("FAIL flush_recover: got v=%b res=%h tag=%0d want v=01 res=5 tag=7",
                     out_valid, res_of(0), tag_of(0));
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        out_ready = 2'b11;
        drive(0, 1'b1, 32'd1, 32'd2, 17'h1, 6'd50);
        drive(1, 1'b1, 32'd3, 32'd4, 17'h1, 6'd51);
        tick();
        tick();
        checks++;
        if (out_valid !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_setup: got out_valid=%b want 11", out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_in_ready: got %b want 00", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 2'b00 || out_result !== '0 || out_tag !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear: got v=%b res=%h tag=%h want all 0", out_valid, out_result, out_tag);
        end
        rst = 1'b0;
        drive(0, 1'b0, '0, '0, '0, '0);
        drive(1, 1'b1, 32'd10, 32'd20, 17'h1, 6'd9);
        tick();
        drive(1, 1'b0, '0, '0, '0, '0);
        checks++;
        if (out_valid !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_no_stale: got out_valid=%b want 00", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 2'b10 || res_of(1) !== 32'd30 || tag_of(1) !== 6'd9) begin
            errors++;
            $display("FAIL rst_mid_recover: got v=%b res=%h tag=%0d want v=10 res=30 tag=9",
                     out_valid, res_of(1), tag_of(1));
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_funcs_lane0();
        test_funcs_lane1();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
